// File: rtl/jk_cmd_gen.sv
// Pushbutton-to-JK command generator: sync, debounce, edge-detect, one-cycle j/k pulse FSM.
// Latency: DEBOUNCE_CYCLES+4 clk edges from a clean raw press to j/k high.
// Backpressure: none; presses arriving while busy are dropped. JK_CMD_GEN_AUTO_REPEAT_EN enables tgl auto-repeat.
module jk_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_clr,
    input  logic       btn_tgl,
    output logic       j,
    output logic       k,
    output logic       busy,
    output logic [7:0] cmd_cnt
);

    // Both counters are 16 bits wide, so both periods must fit that range.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
        $error("jk_cmd_gen: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range 2..65535");
    end

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Bit order for all per-button vectors: [0]=set, [1]=clr, [2]=tgl.
    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  lvl_q;
    logic [2:0]  lvl_dly_q;
    logic [2:0]  press_q;
    logic [15:0] db_cnt_q [3];

    state_t      state_q, state_d;
    logic        j_q, j_d;
    logic        k_q, k_d;
    logic [7:0]  cmd_cnt_q, cmd_cnt_d;

`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
    logic [15:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // Two-flop synchronizer for the raw asynchronous buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_tgl, btn_clr, btn_set};
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    lvl_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Rising-edge press events; lvl_dly_q is the level aligned with press_q so HOLD
    // exit sees the same pipeline depth as press entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_dly_q <= '0;
            press_q   <= '0;
        end else begin
            lvl_dly_q <= lvl_q;
            press_q   <= lvl_q & ~lvl_dly_q;
        end
    end

    // FSM, command outputs and command counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            cmd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            k_q       <= k_d;
            cmd_cnt_q <= cmd_cnt_d;
        end
    end

`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
    // Auto-repeat period counter, only advanced while holding tgl alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    // Next-state logic; j/k are computed for the cycle being entered, so they are high only in PULSE.
    // Encoding j = tgl|set, k = tgl|clr covers single presses and the set+clr -> 11 case.
    always_comb begin
        state_d   = state_q;
        j_d       = 1'b0;
        k_d       = 1'b0;
        cmd_cnt_d = cmd_cnt_q;
`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
        rpt_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|press_q) begin
                    state_d = PULSE;
                    j_d     = press_q[2] | press_q[0];
                    k_d     = press_q[2] | press_q[1];
                end
            end
            PULSE: begin
                state_d = HOLD;
            end
            HOLD: begin
`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
                if (lvl_dly_q == 3'b100) begin
                    if (rpt_cnt_q == RPT_LAST) begin
                        state_d = PULSE;
                        j_d     = 1'b1;
                        k_d     = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 16'd1;
                    end
                end else if (lvl_dly_q == 3'b000) begin
                    state_d = IDLE;
                end
`else
                if (lvl_dly_q == 3'b000) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == PULSE) begin
            cmd_cnt_d = cmd_cnt_q + 8'd1;
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign busy    = (state_q != IDLE);
    assign cmd_cnt = cmd_cnt_q;

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Directed bench for jk_cmd_gen with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Latency: press -> pulse expected 8 edges later; release -> idle 8 edges later.
// Backpressure: n/a; inputs driven 1 time unit after posedge, outputs sampled there too.
module tb_jk_cmd_gen;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_tgl = 1'b0;
    logic       j;
    logic       k;
    logic       busy;
    logic [7:0] cmd_cnt;

    int checks = 0;
    int errors = 0;
    int npulse = 0;
    int p0;

`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
    localparam int   HOLD40_PULSES = 5;
    localparam logic RPT_AT_17     = 1'b1;
`else
    localparam int   HOLD40_PULSES = 1;
    localparam logic RPT_AT_17     = 1'b0;
`endif

    jk_cmd_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_set(btn_set),
        .btn_clr(btn_clr),
        .btn_tgl(btn_tgl),
        .j      (j),
        .k      (k),
        .busy   (busy),
        .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    // Count every cycle with a command on j/k.
    always @(negedge clk) begin
        if (j || k) npulse = npulse + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #10;
        check("rst_j",       32'(j),       32'd0);
        check("rst_k",       32'(k),       32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_cmd_cnt", 32'(cmd_cnt), 32'd0);
        step(2);
        reset = 1'b1;
        step(3);

        // Clean set press held 20 cycles
        p0 = npulse;
        btn_set = 1'b1;
        step(7);
        check("set_early",  32'({j, k}), 32'd0);
        check("set_busy0",  32'(busy),   32'd0);
        step(1);
        check("set_code",   32'({j, k}), 32'b10);
        check("set_busy1",  32'(busy),   32'd1);
        check("set_cnt",    32'(cmd_cnt), 32'd1);
        step(1);
        check("set_width",  32'({j, k}), 32'd0);
        step(11);
        btn_set = 1'b0;
        step(7);
        check("rel_busy_hi", 32'(busy), 32'd1);
        step(1);
        check("rel_busy_lo", 32'(busy), 32'd0);
        check("set_npulse",  32'(npulse - p0), 32'd1);

        // Bouncing clr never debounces
        p0 = npulse;
        for (int i = 0; i < 5; i++) begin
            btn_clr = 1'b1;
            step(2);
            btn_clr = 1'b0;
            step(2);
        end
        step(20);
        check("bounce_npulse", 32'(npulse - p0), 32'd0);
        check("bounce_cnt",    32'(cmd_cnt),     32'd1);
        check("bounce_busy",   32'(busy),        32'd0);

        // set+clr together -> 11; tgl during HOLD ignored
        p0 = npulse;
        btn_set = 1'b1;
        btn_clr = 1'b1;
        step(8);
        check("sc_code", 32'({j, k}), 32'b11);
        step(2);
        btn_tgl = 1'b1;
        step(10);
        btn_tgl = 1'b0;
        step(10);
        btn_set = 1'b0;
        btn_clr = 1'b0;
        step(12);
        check("sc_npulse", 32'(npulse - p0), 32'd1);
        check("sc_cnt",    32'(cmd_cnt),     32'd2);
        check("sc_busy",   32'(busy),        32'd0);

        // Reset during PULSE, button held through release
        btn_set = 1'b1;
        step(8);
        check("pre_rst_pulse", 32'({j, k}), 32'b10);
        reset = 1'b0;
        #1;
        check("rst_pulse_jk",   32'({j, k}),  32'd0);
        check("rst_pulse_cnt",  32'(cmd_cnt), 32'd0);
        check("rst_pulse_busy", 32'(busy),    32'd0);
        step(3);
        reset = 1'b1;
        step(7);
        check("post_rst_early", 32'({j, k}),  32'd0);
        step(1);
        check("post_rst_code",  32'({j, k}),  32'b10);
        check("post_rst_cnt",   32'(cmd_cnt), 32'd1);
        btn_set = 1'b0;
        step(15);
        check("post_rst_idle",  32'(busy),    32'd0);

        // 256 tgl presses wrap the command counter
        p0 = npulse;
        for (int i = 0; i < 256; i++) begin
            btn_tgl = 1'b1;
            step(6);
            btn_tgl = 1'b0;
            step(12);
            if (i == 254) check("wrap_zero", 32'(cmd_cnt), 32'd0);
        end
        check("wrap_back",   32'(cmd_cnt),     32'd1);
        check("wrap_npulse", 32'(npulse - p0), 32'd256);

        // tgl held 40 cycles: auto-repeat or single pulse
        p0 = npulse;
        btn_tgl = 1'b1;
        step(8);
        check("tgl_code",    32'({j, k}), 32'b11);
        step(8);
        check("tgl_gap",     32'({j, k}), 32'd0);
        step(1);
        check("tgl_rpt17",   32'(j),      32'(RPT_AT_17));
        step(23);
        btn_tgl = 1'b0;
        step(20);
        check("tgl_npulse",  32'(npulse - p0), 32'(HOLD40_PULSES));
        check("tgl_busy",    32'(busy),        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
